// File: rtl/button_event_pkg.sv
// Shared types and helpers for the button event classifier.
// State encoding and ms-to-cycle conversion live here so the top stays purely behavioural.
package button_event_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPress1   = 3'd1,
    StWait2    = 3'd2,
    StPress2   = 3'd3,
    StLongHeld = 3'd4
  } state_e;

  function automatic int unsigned ms_to_cycles(int unsigned freq, int unsigned ms);
    return freq / 1000 * ms;
  endfunction

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_event.sv
// Classifies a debounced button level into short, double, long and auto-repeat events.
// Every event output is a registered one-cycle pulse.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200,
  parameter int unsigned DCLICK_MS = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic held,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned Long   = ms_to_cycles(CLK_FREQ, LONG_MS);
  localparam int unsigned Repeat = ms_to_cycles(CLK_FREQ, REPEAT_MS);
  localparam int unsigned Dclick = ms_to_cycles(CLK_FREQ, DCLICK_MS);
  localparam int unsigned CntW   = $clog2(max3(Long, Repeat, Dclick)) + 1;

  localparam logic [CntW-1:0] LongEnd   = CntW'(Long - 1);
  localparam logic [CntW-1:0] RepeatEnd = CntW'(Repeat - 1);
  localparam logic [CntW-1:0] DclickEnd = CntW'(Dclick - 1);

  if (Long < 2) begin : gen_long_chk
    $error("button_event: LONG cycle count must be >= 2");
  end
  if (Repeat < 2) begin : gen_repeat_chk
    $error("button_event: REPEAT cycle count must be >= 2");
  end
  if (Dclick < 2) begin : gen_dclick_chk
    $error("button_event: DCLICK cycle count must be >= 2");
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            btn_q;
  logic            short_q, short_d;
  logic            double_q, double_d;
  logic            long_q, long_d;
  logic            repeat_q, repeat_d;
  logic            rise, fall;

  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      btn_q    <= 1'b0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_q    <= btn_level;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // cnt is unused here and in PRESS2; parked at 0 so it can never wrap
        cnt_d = '0;
        if (rise) state_d = StPress1;
      end
      StPress1: begin
        if (fall) begin
          state_d = StWait2;
        end else if (cnt_q == LongEnd) begin
          state_d = StLongHeld;
          long_d  = 1'b1;
        end
      end
      StWait2: begin
        if (rise) begin
          state_d = StPress2;
        end else if (cnt_q == DclickEnd) begin
          state_d = StIdle;
          short_d = 1'b1;
        end
      end
      StPress2: begin
        cnt_d = '0;
        if (fall) begin
          state_d  = StIdle;
          double_d = 1'b1;
        end
      end
      StLongHeld: begin
        if (fall) begin
          state_d = StIdle;
        end else if (cnt_q == RepeatEnd) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    held         = btn_q;
    short_press  = short_q;
    double_press = double_q;
    long_press   = long_q;
    repeat_pulse = repeat_q;
  end

endmodule
